// File: rtl/conv_patch_feeder_if.sv
// Purpose : pixel/window bus from the patch feeder to the convolution PE array.
// Latency : carries registered feeder outputs; no logic of its own.
// Backpressure: none, the PE side must accept one column every cycle pe_enable is high.
// Ports   : pixels (column bits), patch_size, pe_enable, conv_enable,
//           Xmatch/Ymatch (position flags), win_valid, patch_x/patch_y (window origin).
interface conv_patch_feeder_if #(
   parameter int CW = 5
);
   logic [6:0]    pixels;
   logic [2:0]    patch_size;
   logic          pe_enable;
   logic          conv_enable;
   logic          Xmatch;
   logic          Ymatch;
   logic          win_valid;
   logic [CW-1:0] patch_x;
   logic [CW-1:0] patch_y;

   modport master (
      output pixels, patch_size, pe_enable, conv_enable,
             Xmatch, Ymatch, win_valid, patch_x, patch_y
   );

   modport slave (
      input  pixels, patch_size, pe_enable, conv_enable,
             Xmatch, Ymatch, win_valid, patch_x, patch_y
   );
endinterface

// File: rtl/conv_patch_feeder.sv
// Purpose : holds one boolean image and streams it column by column in stripes of patch_size rows.
// Latency : all outputs registered; first column appears the cycle after start is accepted.
// Backpressure: none, one column per cycle with no bubbles; a drain tail lets the PE pipe empty.
// Ports   : clk/rst; start + cfg_patch_size request a scan; img_wr_* load image rows while idle;
//           x/y_min/max bound the match flags; pe (master) carries the PE bus;
//           busy, done (end pulse) and cfg_err (rejected start pulse) report status.
module conv_patch_feeder #(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int CW        = 5,
   parameter int DRAIN_CYC = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          cfg_patch_size,
   input  logic                img_wr_en,
   input  logic [CW-1:0]       img_wr_row,
   input  logic [IMG_W-1:0]    img_wr_data,
   input  logic [CW-1:0]       x_min,
   input  logic [CW-1:0]       x_max,
   input  logic [CW-1:0]       y_min,
   input  logic [CW-1:0]       y_max,
   conv_patch_feeder_if.master pe,
   output logic                busy,
   output logic                done,
   output logic                cfg_err
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t           state, state_n;
   logic [IMG_W-1:0] img   [IMG_H];
   logic [IMG_W-1:0] img_d [IMG_H];
   logic [2:0]       ps, ps_n;
   logic [CW-1:0]    stripe_y, stripe_n;
   logic [CW-1:0]    col, col_n;
   logic [3:0]       drain_cnt, drain_n;

   logic             ps_legal, wr_ok, last_beat, load_beat;
   logic [CW:0]      row_sum;

   logic [6:0]       pix_n;
   logic             pe_n, wv_n, xm_n, ym_n, conv_n, busy_n, done_n, err_n;
   logic [CW-1:0]    px_n, py_n;
   logic [2:0]       psz_n;

   // stripe_y/col always name the beat currently on the outputs, so the
   // counters and the output registers advance on the same edge.
   always_comb begin
      ps_legal  = (cfg_patch_size == 3'd3) || (cfg_patch_size == 3'd5) ||
                  (cfg_patch_size == 3'd7);
      wr_ok     = img_wr_en && (state == IDLE) && (int'(img_wr_row) < IMG_H);
      last_beat = (int'(stripe_y) == IMG_H - int'(ps)) && (int'(col) == IMG_W - 1);

      // A write in the same cycle as an accepted start must be visible to the
      // first beat, so column reads go through the post-write image.
      img_d = img;
      if (wr_ok)
         img_d[img_wr_row] = img_wr_data;

      state_n   = state;
      ps_n      = ps;
      stripe_n  = stripe_y;
      col_n     = col;
      drain_n   = drain_cnt;
      load_beat = 1'b0;
      err_n     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (ps_legal) begin
                  state_n   = SCAN;
                  ps_n      = cfg_patch_size;
                  stripe_n  = '0;
                  col_n     = '0;
                  load_beat = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         SCAN: begin
            if (last_beat) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               load_beat = 1'b1;
               if (int'(col) == IMG_W - 1) begin
                  col_n    = '0;
                  stripe_n = stripe_y + 1'b1;
               end else begin
                  col_n = col + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (int'(drain_cnt) == DRAIN_CYC - 1)
               state_n = DONE;
            else
               drain_n = drain_cnt + 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      pix_n   = '0;
      row_sum = '0;
      wv_n    = 1'b0;
      xm_n    = 1'b0;
      ym_n    = 1'b0;
      px_n    = '0;
      py_n    = '0;
      pe_n    = load_beat;
      if (load_beat) begin
         for (int i = 0; i < 7; i++) begin
            row_sum = {1'b0, stripe_n} + (CW+1)'(i);
            if ((i < int'(ps_n)) && (int'(row_sum) < IMG_H))
               pix_n[i] = img_d[row_sum[CW-1:0]][col_n];
         end
         // Leading ps-1 columns of a stripe only fill the PE window.
         wv_n = int'(col_n) >= int'(ps_n) - 1;
         if (wv_n) begin
            px_n = col_n - CW'(ps_n) + CW'(1);
            py_n = stripe_n;
            xm_n = (px_n >= x_min) && (px_n <= x_max);
            ym_n = (py_n >= y_min) && (py_n <= y_max);
         end
      end

      conv_n = (state_n == SCAN) || (state_n == DRAIN);
      busy_n = conv_n;
      psz_n  = conv_n ? ps_n : 3'd0;
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ps        <= '0;
         stripe_y  <= '0;
         col       <= '0;
         drain_cnt <= '0;
         for (int r = 0; r < IMG_H; r++)
            img[r] <= '0;
         pe.pixels      <= '0;
         pe.patch_size  <= '0;
         pe.pe_enable   <= 1'b0;
         pe.conv_enable <= 1'b0;
         pe.Xmatch      <= 1'b0;
         pe.Ymatch      <= 1'b0;
         pe.win_valid   <= 1'b0;
         pe.patch_x     <= '0;
         pe.patch_y     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         cfg_err        <= 1'b0;
      end else begin
         state     <= state_n;
         ps        <= ps_n;
         stripe_y  <= stripe_n;
         col       <= col_n;
         drain_cnt <= drain_n;
         img       <= img_d;
         pe.pixels      <= pix_n;
         pe.patch_size  <= psz_n;
         pe.pe_enable   <= pe_n;
         pe.conv_enable <= conv_n;
         pe.Xmatch      <= xm_n;
         pe.Ymatch      <= ym_n;
         pe.win_valid   <= wv_n;
         pe.patch_x     <= px_n;
         pe.patch_y     <= py_n;
         busy           <= busy_n;
         done           <= done_n;
         cfg_err        <= err_n;
      end
   end

endmodule

// File: tb/tb_conv_patch_feeder.sv
// Purpose : directed + randomized scans of conv_patch_feeder against a stripe/column model.
// Latency : expects first beat one cycle after start, drain tail, then a one-cycle done.
// Backpressure: none in the DUT; the bench samples every cycle on the falling edge.
module tb_conv_patch_feeder;
   localparam int W  = 28;
   localparam int H  = 28;
   localparam int CW = 5;
   localparam int DC = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    cfg_patch_size;
   logic          img_wr_en;
   logic [CW-1:0] img_wr_row;
   logic [W-1:0]  img_wr_data;
   logic [CW-1:0] x_min, x_max, y_min, y_max;
   logic          busy, done, cfg_err;

   conv_patch_feeder_if #(.CW(CW)) pe_if ();

   conv_patch_feeder #(.IMG_W(W), .IMG_H(H), .CW(CW), .DRAIN_CYC(DC)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_patch_size(cfg_patch_size),
      .img_wr_en(img_wr_en), .img_wr_row(img_wr_row), .img_wr_data(img_wr_data),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .pe(pe_if.master), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mimg [H];   // reference copy of the image the DUT should hold

   int n_pe, n_wv, n_xy, n_x, n_pix, done_k, last_px, last_py;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic pe, input logic [6:0] pix, input logic wv,
                                      input logic xm, input logic ym,
                                      input logic [CW-1:0] px, input logic [CW-1:0] py,
                                      input logic conv, input logic bsy, input logic dn,
                                      input logic [2:0] psz, input logic err);
      return {4'd0, pe, pix, wv, xm, ym, px, py, conv, bsy, dn, psz, err};
   endfunction

   // patch_x/patch_y only carry meaning while win_valid is high.
   function automatic logic [31:0] obs_vec();
      logic [CW-1:0] px, py;
      px = pe_if.win_valid ? pe_if.patch_x : '0;
      py = pe_if.win_valid ? pe_if.patch_y : '0;
      return mk(pe_if.pe_enable, pe_if.pixels, pe_if.win_valid, pe_if.Xmatch, pe_if.Ymatch,
                px, py, pe_if.conv_enable, busy, done, pe_if.patch_size, cfg_err);
   endfunction

   // Beat b of a scan: stripe b/W, column b%W, window origin (col-ps+1, stripe).
   function automatic logic [31:0] exp_beat(input int ps, input int b);
      int         sy, c, px;
      logic [6:0] pix;
      logic       wv, xm, ym;
      sy  = b / W;
      c   = b % W;
      pix = '0;
      for (int i = 0; i < ps; i++)
         pix[i] = mimg[sy + i][c];
      wv = (c >= ps - 1);
      px = c - ps + 1;
      xm = wv && (px >= int'(x_min)) && (px <= int'(x_max));
      ym = wv && (sy >= int'(y_min)) && (sy <= int'(y_max));
      return mk(1'b1, pix, wv, xm, ym, wv ? CW'(px) : '0, wv ? CW'(sy) : '0,
                1'b1, 1'b1, 1'b0, 3'(ps), 1'b0);
   endfunction

   task automatic write_row(input logic [CW-1:0] r, input logic [W-1:0] d);
      img_wr_en   = 1'b1;
      img_wr_row  = r;
      img_wr_data = d;
      @(negedge clk);
      img_wr_en   = 1'b0;
   endtask

   task automatic load_image();
      for (int r = 0; r < H; r++)
         write_row(CW'(r), mimg[r]);
   endtask

   task automatic rand_image();
      for (int r = 0; r < H; r++)
         mimg[r] = W'({$urandom, $urandom});
   endtask

   // Runs one scan from a falling edge in IDLE, checking every cycle to done.
   task automatic run_scan(input int ps, input bit busy_poke = 1'b0,
                           input bit wr_with_start = 1'b0,
                           input logic [CW-1:0] wr_row = '0,
                           input logic [W-1:0] wr_data = '0,
                           input int abort_at = 0);
      int          nb, nt;
      logic [31:0] e;
      nb = (H - ps + 1) * W;
      nt = nb + DC + 1;
      n_pe = 0; n_wv = 0; n_xy = 0; n_x = 0; n_pix = 0;
      done_k = -1; last_px = -1; last_py = -1;
      start          = 1'b1;
      cfg_patch_size = 3'(ps);
      if (wr_with_start) begin
         img_wr_en   = 1'b1;
         img_wr_row  = wr_row;
         img_wr_data = wr_data;
         mimg[wr_row] = wr_data;
      end
      @(negedge clk);
      start     = 1'b0;
      img_wr_en = 1'b0;
      for (int k = 1; k <= nt; k++) begin
         if (k <= nb)
            e = exp_beat(ps, k - 1);
         else if (k <= nb + DC)
            e = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 3'(ps), 1'b0);
         else
            e = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
         chk($sformatf("scan_ps%0d_cyc%0d", ps, k), obs_vec(), e);
         if (pe_if.pe_enable) begin
            n_pe++;
            last_px = int'(pe_if.patch_x);
            last_py = int'(pe_if.patch_y);
            if (pe_if.pixels != 7'd0) n_pix++;
         end
         if (pe_if.win_valid) n_wv++;
         if (pe_if.Xmatch && pe_if.Ymatch) n_xy++;
         if (pe_if.Xmatch) n_x++;
         if (done && done_k < 0) done_k = k;
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_outputs_clear", obs_vec(), 32'd0);
            for (int j = 0; j < 20; j++) begin
               @(negedge clk);
               chk($sformatf("abort_quiet_%0d", j), {30'd0, done, pe_if.pe_enable}, 32'd0);
            end
            for (int r = 0; r < H; r++) mimg[r] = '0;
            return;
         end
         if (busy_poke && k == 3) begin
            img_wr_en      = 1'b1;
            img_wr_row     = wr_row;
            img_wr_data    = wr_data;
            start          = 1'b1;
            cfg_patch_size = (ps == 3) ? 3'd5 : 3'd3;
         end
         if (busy_poke && k == 4) begin
            img_wr_en = 1'b0;
            start     = 1'b0;
         end
         @(negedge clk);
      end
      chk($sformatf("post_done_idle_ps%0d", ps), obs_vec(), 32'd0);
   endtask

   initial begin
      int          sel;
      logic [W-1:0] d;
      logic [2:0]  bad_ps [5];
      bad_ps[0] = 3'd0; bad_ps[1] = 3'd1; bad_ps[2] = 3'd2; bad_ps[3] = 3'd4; bad_ps[4] = 3'd6;

      rst = 1'b1; start = 1'b0; cfg_patch_size = 3'd3; img_wr_en = 1'b0;
      img_wr_row = '0; img_wr_data = '0;
      x_min = '0; x_max = 5'd27; y_min = '0; y_max = 5'd27;
      for (int r = 0; r < H; r++) mimg[r] = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", obs_vec(), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Illegal patch sizes: one-cycle cfg_err, no scan.
      for (int t = 0; t < 5; t++) begin
         start = 1'b1;
         cfg_patch_size = bad_ps[t];
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("cfg_err_pulse_ps%0d", bad_ps[t]), obs_vec(),
             mk(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("cfg_err_after", obs_vec(), 32'd0);
         end
      end

      // All-ones image, ps=3, full windows.
      for (int r = 0; r < H; r++) mimg[r] = '1;
      load_image();
      run_scan(3);
      chk("ps3_pe_beats", n_pe, 728);
      chk("ps3_win_valid", n_wv, 676);
      chk("ps3_xy_match", n_xy, 676);
      chk("ps3_done_cycle", done_k, 728 + 6 + 1);
      chk("ps3_pixel_beats", n_pix, 728);

      // Single pixel at row 10 col 12, ps=7.
      for (int r = 0; r < H; r++) mimg[r] = '0;
      mimg[10][12] = 1'b1;
      load_image();
      run_scan(7);
      chk("ps7_single_pixel_beats", n_pix, 7);

      // Out-of-range row write is dropped; match window on a random image.
      rand_image();
      load_image();
      write_row(5'd30, '1);
      x_min = 5'd3; x_max = 5'd3; y_min = 5'd2; y_max = 5'd4;
      run_scan(5);
      chk("ps5_xy_match", n_xy, 3);
      chk("ps5_x_match", n_x, 24);

      // Writes, start and cfg change during a scan are all ignored.
      rand_image();
      load_image();
      x_min = 5'($urandom_range(0, 21)); x_max = 5'($urandom_range(0, 27));
      y_min = 5'($urandom_range(0, 21)); y_max = 5'($urandom_range(0, 27));
      run_scan(7, 1'b1, 1'b0, 5'd0, ~mimg[0]);
      chk("ps7_last_patch_x", last_px, 21);
      chk("ps7_last_patch_y", last_py, 21);
      run_scan(7);

      // Row write in the same cycle as start feeds the scan.
      d = W'({$urandom, $urandom});
      run_scan(3, 1'b0, 1'b1, 5'd1, d);

      // Randomized scans.
      for (int t = 0; t < 3; t++) begin
         rand_image();
         load_image();
         x_min = 5'($urandom_range(0, 27)); x_max = 5'($urandom_range(0, 27));
         y_min = 5'($urandom_range(0, 27)); y_max = 5'($urandom_range(0, 27));
         sel = $urandom_range(0, 2);
         run_scan(3 + 2 * sel);
      end

      // Reset mid-scan clears everything; the following scan sees a blank image.
      x_min = '0; x_max = 5'd27; y_min = '0; y_max = 5'd27;
      run_scan(3, 1'b0, 1'b0, '0, '0, 100);
      run_scan(3);
      chk("after_abort_blank", n_pix, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/conv_patch_feeder.md
Name: conv_patch_feeder

Overview:
- Source end of the convolution PE pixel interface.
- Holds one booleanized image and scans it in horizontal stripes of patch_size rows.
- Streams one pixel column per cycle on pixels with pe_enable, and drives conv_enable, patch_size, Xmatch and Ymatch so downstream convolution PEs see full windows with position flags aligned to the window-completing column.
- Sits between the image loader and the clause PE array.

Parameters:
- IMG_W, 28, image width in pixels (columns); must be >= 7.
- IMG_H, 28, image height in pixels (rows); must be >= 7.
- CW, 5, coordinate/row-address width; 2^CW >= max(IMG_W, IMG_H).
- DRAIN_CYC, 6, cycles held after the last column so the PE pipeline empties; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  scan request pulse; honoured only in IDLE.
- cfg_patch_size  in  3  patch size for the next scan; legal values 3, 5, 7.
- img_wr_en  in  1  image row write strobe.
- img_wr_row  in  CW  row index being written.
- img_wr_data  in  IMG_W  row bits; bit c is column c.
- x_min, x_max, y_min, y_max  in  CW each  inclusive patch-position window for the match flags.
- pixels  out  7  column bits; bit i is row stripe_y+i; bits i >= patch_size are 0.
- patch_size  out  3  latched scan patch size; 0 when idle.
- pe_enable  out  1  pixels is valid this cycle.
- conv_enable  out  1  high for the whole SCAN and DRAIN.
- Xmatch, Ymatch  out  1 each  position flags for the window completed by this column.
- win_valid  out  1  this column completes a full patch window.
- patch_x, patch_y  out  CW each  top-left coordinate of the completed window; valid when win_valid.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse at end of scan.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, image store cleared to 0. Reset asserted mid-scan aborts the scan with no done pulse.
- Image store: IMG_H x IMG_W flops.
  - Written when img_wr_en=1, state is IDLE and img_wr_row < IMG_H.
  - Writes while busy, or with an out-of-range row, are ignored.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE handling of start:
  - start=1 with cfg_patch_size in {3,5,7}: latch ps, clear stripe_y=0 and col=0, go to SCAN.
  - start=1 with any other cfg_patch_size: cfg_err=1 next cycle, stay in IDLE.
- SCAN, one beat per cycle with no bubbles:
  - Registered outputs: pe_enable=1 and pixels[i] = img[stripe_y+i][col] for i < ps.
  - col increments each beat.
  - When col = IMG_W-1: col wraps to 0 and stripe_y increments.
  - After beat (stripe_y = IMG_H-ps, col = IMG_W-1), go to DRAIN.
  - The first pe_enable appears the cycle after start is accepted.
- Window flags on each beat:
  - win_valid = (col >= ps-1).
  - patch_x = col-ps+1 and patch_y = stripe_y.
  - Xmatch = win_valid & (x_min <= patch_x <= x_max).
  - Ymatch = win_valid & (y_min <= patch_y <= y_max).
  - All are registered in the same cycle as pixels.
  - Columns 0..ps-2 of each stripe only prime the PE window: win_valid, Xmatch and Ymatch are 0 on those beats.
- Scan totals:
  - Beats per scan = (IMG_H-ps+1)*IMG_W.
  - Windows per scan = (IMG_H-ps+1)*(IMG_W-ps+1).
- DRAIN:
  - pe_enable=0, pixels=0, win_valid=0, Xmatch=0, Ymatch=0.
  - conv_enable and patch_size stay held.
  - Lasts exactly DRAIN_CYC cycles, then go to DONE.
- DONE: single cycle with done=1 and busy=0; patch_size and conv_enable drop to 0; next state is IDLE.
- start during SCAN, DRAIN or DONE: ignored, not queued.
- Simultaneous img_wr_en and start in IDLE: the write commits and the scan uses the updated image.
- patch_size output is constant from the first beat until DONE; a cfg_patch_size change mid-scan has no effect.

Test Plan:
- Reset then idle: rst 2 cycles -> all outputs 0; start with cfg_patch_size=4 -> cfg_err pulse one cycle later, pe_enable never rises.
- Full scan, ps=3, 28x28 all-ones image, x/y windows 0..27:
  - 728 pe_enable beats, contiguous.
  - 676 win_valid beats, each with Xmatch=Ymatch=1.
  - pixels=7'b0000111 throughout.
  - done exactly 728+6+1 cycles after the start cycle.
- Pixel addressing, ps=7, single 1 at row 10 col 12:
  - pixels bit i=1 only on the beat with stripe_y=10-i and col=12, for i=0..6.
  - Upper bits never set beyond bit 6.
- Match window, ps=5, x_min=x_max=3, y_min=2, y_max=4:
  - Xmatch&Ymatch high on exactly 3 beats: patch (3,2), (3,3), (3,4).
  - Xmatch alone high on 24 beats total.
- Boundary and busy writes, ps=7:
  - Last beat has patch_x=21, patch_y=21.
  - img_wr_en during SCAN leaves the image unchanged on the next scan.
- Reset mid-scan at beat 100: the next cycle has busy=0 and pe_enable=0, no done pulse, image all zeros.
